gbsb_solver: RTL and testbench
==============================

Name: gbsb_solver

Overview:
- Fixed-point generalized ballistic simulated-bifurcation (GbSB) Ising solver core.
- Holds N oscillator positions x, momenta y and pump values p, and integrates them for M steps using coupling matrix J.
- Applies an inelastic wall at |x| = 1.0, then reports spins, Ising energy and system Hamiltonian.
- Sits under a host or controller that loads initial state and J, pulses start and waits for done.

Parameters:
- N, 8, number of spins.
- DATA_WIDTH, 32, signed two's-complement word width.
- FRAC_WIDTH, 16, fractional bits (Q(DATA_WIDTH-FRAC_WIDTH).FRAC_WIDTH).
- PER_SPIN, 0, 1 = independent p per spin; 0 = all spins use p0[0].

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-high reset (codebase name retained; 1 = reset).
- start  in  1  one-cycle pulse that begins a run.
- M  in  32  number of integration steps, sampled on start.
- done  out  1  run complete, level.
- step_count  out  32  completed steps in current/last run.
- init_valid  in  1  load x0/y0/p0 into state.
- x0, y0, p0  in  N×DATA_WIDTH  initial position/momentum/pump.
- J  in  N×N×DATA_WIDTH  coupling matrix, must be held stable during a run.
- dt  in  DATA_WIDTH  time step.
- A  in  DATA_WIDTH  coupling gain.
- valid_out  out  1  pulse per completed step.
- x, y  out  N×DATA_WIDTH  current state registers.
- p_global  out  DATA_WIDTH  p[0].
- p_individual  out  N×DATA_WIDTH  p registers.
- spins  out  N  spin i = 1 when x[i] >= 0, else 0.
- energy, hamiltonian  out  DATA_WIDTH  fixed-point results.
- hit_boundary  out  1  OR of boundary_mask.
- boundary_mask  out  N  spins clamped in last step.

Behaviour:
- Reset: state IDLE; x, y, p, step_count, energy, hamiltonian, boundary_mask all 0; done, valid_out, hit_boundary all 0.
- States and transitions:
  - IDLE / DONE + start → RUN; samples M, clears step_count, clears done.
  - RUN: one full step per cycle.
  - After step_count reaches M → FINAL for 1 cycle, then DONE; done = 1 and held until the next start.
  - M = 0 → FINAL directly.
- init_valid in IDLE/DONE loads state:
  - x = x0, y = y0.
  - p[i] = p0[i] when PER_SPIN = 1, otherwise p0[0].
  - Also clears boundary_mask.
  - init_valid and start in the same cycle: load wins, start is ignored.
  - init_valid and start are both ignored in RUN/FINAL.
- Step i (all spins in parallel, from the old x):
  - h_i = Σ_j J[i][j]·x_j.
  - y' = y + dt·((p_i − 1.0)·x_i + A·h_i).
  - x' = x + dt·y'.
  - If |x'| > 1.0: x = ±1.0 (sign of x'), y = 0, boundary_mask[i] = 1; otherwise mask bit 0.
  - valid_out = 1 and step_count += 1 on that cycle; p is constant during a run.
- Arithmetic:
  - Every product is computed at full precision, then arithmetically shifted right by FRAC_WIDTH.
  - Sums are accumulated at DATA_WIDTH+FRAC_WIDTH+clog2(N)+2 bits.
  - Final values saturate to the DATA_WIDTH signed range; no wrap-around.
- FINAL computation, registered at the end of FINAL, with s_i = +1/−1 from spins:
  - energy = −½·Σ_i Σ_j J[i][j]·s_i·s_j.
  - hamiltonian = Σ_i (½y_i² + ½(1.0 − p_i)x_i²) − ½A·Σ_i x_i·h_i.
- Reset mid-run: returns to the reset state on the next edge; the run is aborted.

Test Plan:
- Reset: hold rst_n = 1 for 5 cycles → all outputs 0, done = 0.
- Zero fixed point: N = 8, J off-diagonal 0x8000 / diagonal 0, x0 = y0 = 0, p0 = 0x10000, dt = 0x10000, A = 0, M = 50 → 50 valid_out pulses, x and y stay 0, step_count = 50, spins = 0xFF, energy = 0xFFF2_0000 (−14.0), hamiltonian = 0, hit_boundary = 0, done 52 cycles after start.
- Wall: x0[0] = 0x0000_C000, y0[0] = 0x0001_0000, all other spins 0, J = 0, p = 1.0, dt = 1.0, M = 1 → x[0] = 0x0001_0000, y[0] = 0, boundary_mask = 0x01, hit_boundary = 1.
- Negative spin: x0[3] = 0xFFFF_8000, J = 0, p = 1.0, y = 0, M = 3 → x[3] is unchanged, spins[3] = 0, energy = 0.
- M = 0: start → step_count = 0, no valid_out pulse, done after 2 cycles.
- Protocol: start or init_valid pulsed mid-run is ignored; rst_n asserted mid-run → outputs are 0 next cycle; a new start from DONE clears done and step_count.

Source files
------------

// File: rtl/gbsb_solver.sv
// gbsb_solver: fixed-point generalized ballistic simulated-bifurcation Ising core.
// Integrates N oscillators (x, y, p) under coupling J for M steps, one full
// parallel step per clock. It clamps each |x| at 1.0 and then reports spins,
// Ising energy and the system Hamiltonian.
//
// Handshake: start and init_valid are single-cycle strobes. They are accepted
// only in IDLE or DONE, and init_valid wins when both arrive together.
// valid_out pulses once per completed step. done is a level that rises one
// cycle after the last step, once energy and hamiltonian are registered, and
// it is held until the next accepted start.
module gbsb_solver #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_WIDTH = 16,
    parameter int PER_SPIN   = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [31:0]               M,
    output logic                      done,
    output logic [31:0]               step_count,
    input  logic                      init_valid,
    input  logic [N*DATA_WIDTH-1:0]   x0,
    input  logic [N*DATA_WIDTH-1:0]   y0,
    input  logic [N*DATA_WIDTH-1:0]   p0,
    input  logic [N*N*DATA_WIDTH-1:0] J,
    input  logic [DATA_WIDTH-1:0]     dt,
    input  logic [DATA_WIDTH-1:0]     A,
    output logic                      valid_out,
    output logic [N*DATA_WIDTH-1:0]   x,
    output logic [N*DATA_WIDTH-1:0]   y,
    output logic [DATA_WIDTH-1:0]     p_global,
    output logic [N*DATA_WIDTH-1:0]   p_individual,
    output logic [N-1:0]              spins,
    output logic [DATA_WIDTH-1:0]     energy,
    output logic [DATA_WIDTH-1:0]     hamiltonian,
    output logic                      hit_boundary,
    output logic [N-1:0]              boundary_mask,
    output logic [1:0]                state_dbg
);
    localparam int DW = DATA_WIDTH;
    localparam int FW = FRAC_WIDTH;
    localparam int PW = 2 * DW;
    localparam int AW = DW + FW + $clog2(N) + 2;

    localparam logic signed [DW-1:0] ONE     = DW'(64'd1 << FW);
    localparam logic signed [DW-1:0] NEG_ONE = -ONE;
    localparam logic signed [DW-1:0] MAXV    = {1'b0, {(DW-1){1'b1}}};
    localparam logic signed [DW-1:0] MINV    = {1'b1, {(DW-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Full-precision product, rescaled back to Q format and widened for accumulation.
    function automatic logic signed [AW-1:0] mul_q(input logic signed [DW-1:0] a,
                                                   input logic signed [DW-1:0] b);
        logic signed [PW-1:0] prod;
        prod = a * b;
        return AW'(prod >>> FW);
    endfunction

    // Clamp a wide accumulator into the signed DW range.
    function automatic logic signed [DW-1:0] sat(input logic signed [AW-1:0] v);
        if (v > AW'(MAXV)) return MAXV;
        else if (v < AW'(MINV)) return MINV;
        else return v[DW-1:0];
    endfunction

    logic [1:0]           state_q;
    logic [31:0]          m_q;
    logic [31:0]          step_count_q;
    logic                 done_q;
    logic                 valid_q;
    logic [N-1:0]         mask_q;
    logic signed [DW-1:0] energy_q;
    logic signed [DW-1:0] hamiltonian_q;
    logic signed [DW-1:0] x_q [N];
    logic signed [DW-1:0] y_q [N];
    logic signed [DW-1:0] p_q [N];

    logic signed [DW-1:0] j_s [N][N];
    logic signed [DW-1:0] a_s;
    logic signed [DW-1:0] dt_s;
    logic [N-1:0]         spins_v;

    // Unpack the flat input buses and derive the spin signs from the positions.
    always_comb begin
        a_s  = signed'(A);
        dt_s = signed'(dt);
        for (int i = 0; i < N; i++) begin
            spins_v[i] = ~x_q[i][DW-1];
            for (int j = 0; j < N; j++) begin
                j_s[i][j] = signed'(J[(i*N+j)*DW +: DW]);
            end
        end
    end

    logic signed [AW-1:0] h_acc [N];
    logic signed [DW-1:0] h_v   [N];

    // Local field h_i = sum_j J[i][j]*x_j from the current positions.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            h_acc[i] = '0;
            for (int j = 0; j < N; j++) begin
                h_acc[i] = h_acc[i] + mul_q(j_s[i][j], x_q[j]);
            end
            h_v[i] = sat(h_acc[i]);
        end
    end

    logic signed [DW-1:0] pm1_v    [N];
    logic signed [DW-1:0] force_v  [N];
    logic signed [DW-1:0] y_int    [N];
    logic signed [AW-1:0] x_wide   [N];
    logic signed [DW-1:0] x_step_d [N];
    logic signed [DW-1:0] y_step_d [N];
    logic [N-1:0]         mask_d;

    // One symplectic step per spin: momentum first, then position, then the wall.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            pm1_v[i]   = sat(AW'(p_q[i]) - AW'(ONE));
            force_v[i] = sat(mul_q(pm1_v[i], x_q[i]) + mul_q(a_s, h_v[i]));
            y_int[i]   = sat(AW'(y_q[i]) + mul_q(dt_s, force_v[i]));
            x_wide[i]  = AW'(x_q[i]) + mul_q(dt_s, y_int[i]);
            mask_d[i]  = 1'b0;
            x_step_d[i] = x_wide[i][DW-1:0];
            y_step_d[i] = y_int[i];
            // Inelastic wall: pin to +/-1.0 and kill the momentum.
            if (x_wide[i] > AW'(ONE)) begin
                x_step_d[i] = ONE;
                y_step_d[i] = '0;
                mask_d[i]   = 1'b1;
            end else if (x_wide[i] < AW'(NEG_ONE)) begin
                x_step_d[i] = NEG_ONE;
                y_step_d[i] = '0;
                mask_d[i]   = 1'b1;
            end
        end
    end

    logic signed [AW-1:0] e_acc;
    logic signed [AW-1:0] ham_acc;
    logic signed [AW-1:0] xh_acc;
    logic signed [DW-1:0] omp_v;
    logic signed [DW-1:0] x2_v;
    logic signed [DW-1:0] energy_d;
    logic signed [DW-1:0] hamiltonian_d;

    // Ising energy and Hamiltonian from the final state, captured in FINAL.
    always_comb begin
        e_acc   = '0;
        ham_acc = '0;
        xh_acc  = '0;
        omp_v   = '0;
        x2_v    = '0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                // s_i*s_j is +1 for matching spins, -1 otherwise.
                if (spins_v[i] == spins_v[j]) e_acc = e_acc + AW'(j_s[i][j]);
                else                          e_acc = e_acc - AW'(j_s[i][j]);
            end
            omp_v   = sat(AW'(ONE) - AW'(p_q[i]));
            x2_v    = sat(mul_q(x_q[i], x_q[i]));
            ham_acc = ham_acc + (mul_q(y_q[i], y_q[i]) >>> 1) + (mul_q(omp_v, x2_v) >>> 1);
            xh_acc  = xh_acc + mul_q(x_q[i], h_v[i]);
        end
        ham_acc       = ham_acc - (mul_q(a_s, sat(xh_acc)) >>> 1);
        energy_d      = sat((-e_acc) >>> 1);
        hamiltonian_d = sat(ham_acc);
    end

    // Control FSM and state registers.
    always_ff @(posedge clk) begin
        valid_q <= 1'b0;
        if (rst_n) begin
            state_q       <= S_IDLE;
            m_q           <= '0;
            step_count_q  <= '0;
            done_q        <= 1'b0;
            mask_q        <= '0;
            energy_q      <= '0;
            hamiltonian_q <= '0;
            for (int i = 0; i < N; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                p_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (init_valid) begin
                        mask_q <= '0;
                        for (int i = 0; i < N; i++) begin
                            x_q[i] <= signed'(x0[i*DW +: DW]);
                            y_q[i] <= signed'(y0[i*DW +: DW]);
                            p_q[i] <= (PER_SPIN != 0) ? signed'(p0[i*DW +: DW])
                                                      : signed'(p0[DW-1:0]);
                        end
                    end else if (start) begin
                        m_q          <= M;
                        step_count_q <= '0;
                        done_q       <= 1'b0;
                        state_q      <= (M == 32'd0) ? S_FINAL : S_RUN;
                    end
                end
                S_RUN: begin
                    mask_q       <= mask_d;
                    step_count_q <= step_count_q + 32'd1;
                    valid_q      <= 1'b1;
                    for (int i = 0; i < N; i++) begin
                        x_q[i] <= x_step_d[i];
                        y_q[i] <= y_step_d[i];
                    end
                    if (step_count_q + 32'd1 >= m_q) state_q <= S_FINAL;
                end
                S_FINAL: begin
                    energy_q      <= energy_d;
                    hamiltonian_q <= hamiltonian_d;
                    done_q        <= 1'b1;
                    state_q       <= S_DONE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Flatten internal arrays onto the output buses.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            x[i*DW +: DW]            = x_q[i];
            y[i*DW +: DW]            = y_q[i];
            p_individual[i*DW +: DW] = p_q[i];
        end
    end

    assign p_global      = p_q[0];
    assign spins         = spins_v;
    assign done          = done_q;
    assign step_count    = step_count_q;
    assign valid_out     = valid_q;
    assign energy        = energy_q;
    assign hamiltonian   = hamiltonian_q;
    assign boundary_mask = mask_q;
    assign hit_boundary  = |mask_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_gbsb_solver.sv
// Testbench for gbsb_solver: table of directed runs plus protocol sequences.
module tb_gbsb_solver;
    localparam int N  = 8;
    localparam int DW = 32;
    localparam int VW = N * DW;
    localparam int JW = N * N * DW;
    localparam int NV = 8;
    localparam logic [DW-1:0] ONE = 32'h0001_0000;

    logic          clk;
    logic          rst;
    logic          start;
    logic [31:0]   m_in;
    logic          done;
    logic [31:0]   step_count;
    logic          init_valid;
    logic [VW-1:0] x0_in, y0_in, p0_in;
    logic [JW-1:0] j_in;
    logic [DW-1:0] dt_in, a_in;
    logic          valid_out;
    logic [VW-1:0] x_out, y_out, p_ind;
    logic [DW-1:0] p_global;
    logic [N-1:0]  spins;
    logic [DW-1:0] energy, hamiltonian;
    logic          hit_boundary;
    logic [N-1:0]  boundary_mask;
    logic [1:0]    state_dbg;

    gbsb_solver #(.N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(16), .PER_SPIN(0)) dut (
        .clk(clk), .rst_n(rst), .start(start), .M(m_in), .done(done),
        .step_count(step_count), .init_valid(init_valid),
        .x0(x0_in), .y0(y0_in), .p0(p0_in), .J(j_in), .dt(dt_in), .A(a_in),
        .valid_out(valid_out), .x(x_out), .y(y_out), .p_global(p_global),
        .p_individual(p_ind), .spins(spins), .energy(energy),
        .hamiltonian(hamiltonian), .hit_boundary(hit_boundary),
        .boundary_mask(boundary_mask), .state_dbg(state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]   m;
        logic [VW-1:0] x0, y0, p0;
        logic [JW-1:0] j;
        logic [DW-1:0] dt, a;
        logic [VW-1:0] ex, ey;
        logic [N-1:0]  emask, espins;
        logic [DW-1:0] eenergy, eham;
    } vec_t;

    vec_t vecs [NV];
    int   tests = 0;
    int   fails = 0;
    int   cyc;
    int   pulses;

    task automatic check(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (valid_out) pulses++;
    endtask

    task automatic load(input logic [VW-1:0] xv, input logic [VW-1:0] yv, input logic [VW-1:0] pv);
        x0_in = xv; y0_in = yv; p0_in = pv;
        init_valid = 1'b1;
        @(negedge clk);
        init_valid = 1'b0;
    endtask

    task automatic begin_run(input logic [31:0] m);
        m_in = m; start = 1'b1;
        cyc = 0; pulses = 0;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        while (!done && cyc < limit) tick();
    endtask

    function automatic logic [JW-1:0] j_half();
        logic [JW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (i != j) r[(i*N+j)*DW +: DW] = 32'h0000_8000;
        return r;
    endfunction

    initial begin
        logic [VW-1:0] xv;
        logic [VW-1:0] pv;
        rst = 1'b1; start = 1'b0; init_valid = 1'b0; m_in = '0;
        x0_in = '0; y0_in = '0; p0_in = '0; j_in = '0; dt_in = '0; a_in = '0;

        for (int k = 0; k < NV; k++) begin
            vecs[k].m = 32'd1; vecs[k].x0 = '0; vecs[k].y0 = '0; vecs[k].p0 = {N{ONE}};
            vecs[k].j = '0; vecs[k].dt = ONE; vecs[k].a = '0;
            vecs[k].ex = '0; vecs[k].ey = '0; vecs[k].emask = '0; vecs[k].espins = 8'hFF;
            vecs[k].eenergy = '0; vecs[k].eham = '0;
        end
        // 0: zero fixed point, all spins +1 against J=0.5 off-diagonal
        vecs[0].m = 32'd50; vecs[0].j = j_half(); vecs[0].eenergy = 32'hFFF2_0000;
        // 1: positive wall
        vecs[1].x0[0 +: DW] = 32'h0000_C000; vecs[1].y0[0 +: DW] = 32'h0001_0000;
        vecs[1].ex[0 +: DW] = 32'h0001_0000; vecs[1].emask = 8'h01;
        // 2: negative wall
        vecs[2].x0[0 +: DW] = 32'hFFFF_4000; vecs[2].y0[0 +: DW] = 32'hFFFF_0000;
        vecs[2].ex[0 +: DW] = 32'hFFFF_0000; vecs[2].emask = 8'h01; vecs[2].espins = 8'hFE;
        // 3: negative spin at rest stays put
        vecs[3].m = 32'd3; vecs[3].x0[3*DW +: DW] = 32'hFFFF_8000;
        vecs[3].ex[3*DW +: DW] = 32'hFFFF_8000; vecs[3].espins = 8'hF7;
        // 4: two coupled spins, A = 0.5, dt = 0.5
        vecs[4].j[(0*N+1)*DW +: DW] = ONE; vecs[4].j[(1*N+0)*DW +: DW] = ONE;
        vecs[4].x0[1*DW +: DW] = 32'h0000_8000; vecs[4].a = 32'h0000_8000; vecs[4].dt = 32'h0000_8000;
        vecs[4].ex[0 +: DW] = 32'h0000_1000; vecs[4].ex[1*DW +: DW] = 32'h0000_8000;
        vecs[4].ey[0 +: DW] = 32'h0000_2000;
        vecs[4].eenergy = 32'hFFFF_0000; vecs[4].eham = 32'hFFFF_FE00;
        // 5: pump 0.5 pulls x toward 0, one step
        vecs[5].p0 = {N{32'h0000_8000}}; vecs[5].x0[2*DW +: DW] = 32'h0000_8000;
        vecs[5].ex[2*DW +: DW] = 32'h0000_4000; vecs[5].ey[2*DW +: DW] = 32'hFFFF_C000;
        vecs[5].eham = 32'h0000_0C00;
        // 6: same as 5 over two steps, x crosses zero
        vecs[6] = vecs[5]; vecs[6].m = 32'd2;
        vecs[6].ex[2*DW +: DW] = 32'hFFFF_E000; vecs[6].ey[2*DW +: DW] = 32'hFFFF_A000;
        vecs[6].espins = 8'hFB; vecs[6].eham = 32'h0000_1300;
        // 7: M = 0 goes straight to FINAL
        vecs[7].m = 32'd0; vecs[7].x0[5*DW +: DW] = 32'hFFFF_0000; vecs[7].y0[5*DW +: DW] = ONE;
        vecs[7].ex[5*DW +: DW] = 32'hFFFF_0000; vecs[7].ey[5*DW +: DW] = ONE;
        vecs[7].espins = 8'hDF; vecs[7].eham = 32'h0000_8000;

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_valid", valid_out, 0);
        check("rst_step_count", step_count, 0);
        check("rst_x", x_out, 0);
        check("rst_y", y_out, 0);
        check("rst_p", p_ind, 0);
        check("rst_energy", energy, 0);
        check("rst_ham", hamiltonian, 0);
        check("rst_mask", boundary_mask, 0);
        check("rst_hit", hit_boundary, 0);
        check("rst_spins", spins, 8'hFF);
        check("rst_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        // init_valid and start together: load wins, no run starts
        xv = {N{32'h0000_4000}};
        pv = '0;
        for (int i = 0; i < N; i++) pv[i*DW +: DW] = 32'h0000_1000 * (i + 1);
        pv[0 +: DW] = ONE;
        x0_in = xv; y0_in = '0; p0_in = pv; m_in = 32'd5;
        init_valid = 1'b1; start = 1'b1;
        cyc = 0; pulses = 0;
        tick();
        init_valid = 1'b0; start = 1'b0;
        check("load_x", x_out, xv);
        check("load_p_shared", p_ind, {N{ONE}});
        check("load_p_global", p_global, ONE);
        repeat (3) tick();
        check("load_no_run_pulses", pulses, 0);
        check("load_no_run_steps", step_count, 0);
        check("load_no_run_done", done, 0);

        // Table of directed runs
        for (int k = 0; k < NV; k++) begin
            j_in = vecs[k].j; dt_in = vecs[k].dt; a_in = vecs[k].a;
            load(vecs[k].x0, vecs[k].y0, vecs[k].p0);
            begin_run(vecs[k].m);
            wait_done(int'(vecs[k].m) + 40);
            check($sformatf("v%0d_cycles", k), cyc, vecs[k].m + 2);
            check($sformatf("v%0d_pulses", k), pulses, vecs[k].m);
            check($sformatf("v%0d_step_count", k), step_count, vecs[k].m);
            check($sformatf("v%0d_x", k), x_out, vecs[k].ex);
            check($sformatf("v%0d_y", k), y_out, vecs[k].ey);
            check($sformatf("v%0d_mask", k), boundary_mask, vecs[k].emask);
            check($sformatf("v%0d_hit", k), hit_boundary, |vecs[k].emask);
            check($sformatf("v%0d_spins", k), spins, vecs[k].espins);
            check($sformatf("v%0d_energy", k), energy, vecs[k].eenergy);
            check($sformatf("v%0d_ham", k), hamiltonian, vecs[k].eham);
        end

        // Mid-run start and init_valid are ignored
        j_in = j_half(); dt_in = ONE; a_in = '0;
        load('0, '0, {N{ONE}});
        begin_run(32'd10);
        tick(); tick();
        m_in = 32'd1; start = 1'b1; init_valid = 1'b1; x0_in = {N{32'h0000_4000}};
        tick();
        start = 1'b0; init_valid = 1'b0;
        wait_done(60);
        check("mid_cycles", cyc, 12);
        check("mid_pulses", pulses, 10);
        check("mid_step_count", step_count, 10);
        check("mid_x", x_out, 0);
        check("mid_energy", energy, 32'hFFF2_0000);

        // New start from DONE clears done and step_count
        begin_run(32'd5);
        check("restart_done", done, 0);
        check("restart_step_count", step_count, 0);
        tick(); tick();
        check("prerst_step_count", step_count, 2);

        // Reset mid-run aborts on the next edge
        rst = 1'b1;
        @(negedge clk);
        check("abort_step_count", step_count, 0);
        check("abort_done", done, 0);
        check("abort_valid", valid_out, 0);
        check("abort_energy", energy, 0);
        check("abort_p_global", p_global, 0);
        check("abort_state", state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
